// File: rtl/awmc_plant_monitor.sv
`default_nettype none
// ============================================================================
// Module   : awmc_plant_monitor
// Purpose  : Plant model and safety checker for the washing-machine controller:
//            integrates drum level, checks stage order and lid, sticky faults.
// Revision : 1.0  initial release
// ============================================================================
module awmc_plant_monitor #(
    parameter int LEVEL_W    = 4,
    parameter int LEVEL_MAX  = 15,
    parameter int FILL_RATE  = 2,
    parameter int DRAIN_RATE = 3,
    parameter int LID_GRACE  = 2,
    parameter int CNT_W      = 8
) (
    input  logic               c_in,
    input  logic               reset,
    input  logic               clk,
    input  logic [2:0]         stage,
    input  logic               done,
    input  logic               input_valve,
    input  logic               output_drain,
    input  logic               lid,
    input  logic               fault_clr,
    output logic [LEVEL_W-1:0] level,
    output logic [4:0]         fault,
    output logic               fault_any,
    output logic [CNT_W-1:0]   cycles_done,
    output logic [CNT_W-1:0]   stage_ticks
);

    typedef enum logic [2:0] {
        STG_FILL  = 3'd0,
        STG_WASH  = 3'd1,
        STG_RINSE = 3'd2,
        STG_SPIN  = 3'd3,
        STG_STOP  = 3'd4,
        STG_IDLE  = 3'd7
    } stage_t;

    localparam int                 c_LID_W     = $clog2(LID_GRACE + 2);
    localparam logic [c_LID_W-1:0] c_LID_SAT   = c_LID_W'(LID_GRACE + 1);
    localparam logic [c_LID_W-1:0] c_LID_GRACE = c_LID_W'(LID_GRACE);
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = '1;
    localparam logic [LEVEL_W:0]   c_LVL_MAX   = (LEVEL_W + 1)'(LEVEL_MAX);
    localparam logic [LEVEL_W:0]   c_FILL      = (LEVEL_W + 1)'(FILL_RATE);
    localparam logic [LEVEL_W:0]   c_DRAIN     = (LEVEL_W + 1)'(DRAIN_RATE);

    logic [LEVEL_W-1:0] r_level;
    logic [4:0]         r_fault;
    logic               r_fault_any;
    logic [CNT_W-1:0]   r_cycles;
    logic [CNT_W-1:0]   r_ticks;
    logic [2:0]         r_prev_stage;
    logic [2:0]         r_last_active;
    logic [c_LID_W-1:0] r_lid_cnt;
    logic               r_done_d;

    logic [LEVEL_W:0]   w_level_ext;
    logic [LEVEL_W:0]   w_fill_sum;
    logic [LEVEL_W:0]   w_level_next;
    logic               w_conflict;
    logic               w_overflow;
    logic               w_changed;
    logic               w_legal_step;
    logic               w_seq_fault;
    logic               w_lid_active;
    logic               w_lid_fault;
    logic [c_LID_W-1:0] w_lid_next;
    logic               w_done_rise;
    logic               w_done_fault;
    logic [4:0]         w_fault_set;
    logic [4:0]         w_fault_next;

    // Level arithmetic is one bit wider than the register so sums never wrap.
    assign w_level_ext = {1'b0, r_level};
    assign w_fill_sum  = w_level_ext + c_FILL;
    assign w_conflict  = input_valve & output_drain;
    assign w_overflow  = input_valve & (w_level_ext == c_LVL_MAX);

    always_comb begin
        w_level_next = w_level_ext;
        if (input_valve && !output_drain) begin
            w_level_next = (w_fill_sum > c_LVL_MAX) ? c_LVL_MAX : w_fill_sum;
        end else if (output_drain && !input_valve) begin
            w_level_next = (w_level_ext >= c_DRAIN) ? (w_level_ext - c_DRAIN) : '0;
        end
    end

    assign w_changed = (stage != r_prev_stage);

    always_comb begin
        w_legal_step = 1'b0;
        if (stage == STG_IDLE) begin
            w_legal_step = 1'b1;
        end else if (r_prev_stage == STG_IDLE) begin
            // Fresh start needs no remembered stage; otherwise only resume is allowed.
            w_legal_step = ((stage == STG_FILL) && (r_last_active == STG_IDLE)) ||
                           (stage == r_last_active);
        end else begin
            w_legal_step = ((r_prev_stage == STG_FILL)  && (stage == STG_WASH))  ||
                           ((r_prev_stage == STG_WASH)  && (stage == STG_RINSE)) ||
                           ((r_prev_stage == STG_RINSE) && (stage == STG_SPIN))  ||
                           ((r_prev_stage == STG_SPIN)  && (stage == STG_STOP));
        end
    end

    assign w_seq_fault = (stage == 3'd5) || (stage == 3'd6) || (w_changed && !w_legal_step);

    assign w_lid_active = lid && ((stage == STG_WASH) || (stage == STG_RINSE) ||
                                  (stage == STG_SPIN));
    assign w_lid_fault  = w_lid_active && (r_lid_cnt >= c_LID_GRACE);
    assign w_lid_next   = !w_lid_active ? '0 :
                          (r_lid_cnt == c_LID_SAT) ? r_lid_cnt : (r_lid_cnt + c_LID_W'(1));

    assign w_done_rise  = done && !r_done_d;
    assign w_done_fault = w_done_rise && (r_prev_stage != STG_STOP);

    // New detections are OR-ed in after the clear so a same-tick event survives.
    assign w_fault_set  = {w_done_fault, w_overflow, w_lid_fault, w_seq_fault, w_conflict};
    assign w_fault_next = (fault_clr ? 5'b0 : r_fault) | w_fault_set;

    always_ff @(posedge c_in or posedge reset) begin
        if (reset) begin
            r_level       <= '0;
            r_fault       <= '0;
            r_fault_any   <= 1'b0;
            r_cycles      <= '0;
            r_ticks       <= '0;
            r_prev_stage  <= STG_IDLE;
            r_last_active <= STG_IDLE;
            r_lid_cnt     <= '0;
            r_done_d      <= 1'b0;
        end else if (clk) begin
            r_level     <= w_level_next[LEVEL_W-1:0];
            r_fault     <= w_fault_next;
            r_fault_any <= |w_fault_next;
            r_lid_cnt   <= w_lid_next;
            r_done_d    <= done;
            r_prev_stage <= stage;
            if (w_done_rise && (r_cycles != c_CNT_MAX)) begin
                r_cycles <= r_cycles + CNT_W'(1);
            end
            if (w_changed) begin
                r_ticks <= CNT_W'(1);
            end else if (r_ticks != c_CNT_MAX) begin
                r_ticks <= r_ticks + CNT_W'(1);
            end
            // A finished program (STOP) forgets its place; a pause remembers it.
            if (w_changed && (stage == STG_IDLE)) begin
                r_last_active <= (r_prev_stage == STG_STOP) ? STG_IDLE : r_prev_stage;
            end
        end
    end

    assign level       = r_level;
    assign fault       = r_fault;
    assign fault_any   = r_fault_any;
    assign cycles_done = r_cycles;
    assign stage_ticks = r_ticks;

endmodule
`default_nettype wire

// File: doc/awmc_plant_monitor.md
Name: awmc_plant_monitor

Overview:
- Plant-side model and checker sitting on the far end of the washing-machine controller's command interface.
- Consumes the controller's stage, done, input_valve and output_drain outputs plus the lid sensor.
- Integrates a drum water level, checks the stage sequence and lid interlock, and raises sticky fault flags.
- Counts completed wash cycles; used in the top-level bench and as an on-chip safety monitor.

Parameters:
- LEVEL_W, 4: width of the water-level register.
- LEVEL_MAX, 15: saturation ceiling for level (≤ 2^LEVEL_W−1).
- FILL_RATE, 2: level increment per tick while filling.
- DRAIN_RATE, 3: level decrement per tick while draining.
- LID_GRACE, 2: ticks lid may read 1 in WASH/RINSE/SPIN before fault.
- CNT_W, 8: width of cycles_done and stage_ticks.

Ports:
- c_in  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- clk  input  1  tick enable; sampling and updates occur only on posedge c_in with clk=1.
- stage  input  3  controller stage: IDLE=7, FILL=0, WASH=1, RINSE=2, SPIN=3, STOP=4; 5 and 6 are illegal.
- done  input  1  controller cycle-complete flag (level, may stay high).
- input_valve  input  1  fill command.
- output_drain  input  1  drain command.
- lid  input  1  lid sensor.
- fault_clr  input  1  clears sticky faults (sampled on tick).
- level  output  LEVEL_W  modelled water level.
- fault  output  5  sticky fault vector.
- fault_any  output  1  OR of fault.
- cycles_done  output  CNT_W  count of done rising edges, saturating.
- stage_ticks  output  CNT_W  ticks spent in the current stage, saturating.

Behaviour:
- Reset (async): level=0, fault=0, fault_any=0, cycles_done=0, stage_ticks=0; internal prev_stage=IDLE, last_active=IDLE, lid_cnt=0, done_d=0.
- No tick (clk=0): all registers hold.
- Latency: all outputs are registered. Effect of tick N inputs is visible after the posedge c_in of tick N. fault_any is registered alongside fault, not derived combinationally.
- Level model, per tick:
  - valve=1, drain=0: level = min(level+FILL_RATE, LEVEL_MAX).
  - drain=1, valve=0: level = max(level−DRAIN_RATE, 0).
  - Both 1: level unchanged; set fault[0] CONFLICT.
  - Arithmetic uses LEVEL_W+1 bits internally, so there is no wrap.
- fault[3] OVERFLOW: set when valve=1 and level==LEVEL_MAX at the tick.
- Stage checker (compares stage vs prev_stage each tick; no check if equal). Legal changes:
  - any non-IDLE → IDLE (pause/lid hold). last_active takes the old stage, except STOP→IDLE, which sets last_active=IDLE.
  - IDLE → FILL if last_active==IDLE.
  - IDLE → last_active (resume).
  - FILL→WASH, WASH→RINSE, RINSE→SPIN, SPIN→STOP.
  - Anything else, or stage ∈ {5,6} on any tick, sets fault[1] SEQUENCE.
  - prev_stage updates every tick regardless.
- Lid interlock: lid_cnt increments (saturating at LID_GRACE+1) while stage ∈ {WASH,RINSE,SPIN} and lid=1; it clears otherwise. Set fault[2] LID when lid_cnt would exceed LID_GRACE (i.e. the (LID_GRACE+1)th consecutive tick).
- fault[4] DONE_SEQ: set on done rising edge (done=1, done_d=0) when prev_stage != STOP.
- cycles_done: +1 on every done rising edge regardless of DONE_SEQ; saturates at all-ones.
- stage_ticks: resets to 1 on the tick where stage != prev_stage; otherwise +1, saturating.
- fault_clr on a tick clears all fault bits. Any fault condition detected in the same tick is still set, so set wins and no event is lost. level and counters are unaffected by fault_clr.
- Reset asserted mid-cycle returns everything to reset values immediately. The first post-reset stage change must be IDLE→FILL to be legal.

Test Plan:
- Normal cycle, LID_GRACE=2: stage IDLE→FILL→WASH→RINSE→SPIN→STOP→IDLE, lid 0 after FILL, done pulse on STOP→IDLE → fault=0, cycles_done=1.
- Fill/drain: valve=1 for 9 ticks from level 0 → level reaches 15 at tick 8, fault[3] set on tick 9; then drain=1 for 6 ticks → level 0, no further change.
- Conflict: valve=1 and drain=1 on one tick at level 6 → level stays 6, fault=5'b00001, fault_any=1; fault_clr tick → fault=0.
- Sequence: WASH→IDLE→RINSE → fault[1] set; separately WASH→IDLE→WASH → no fault; stage=5 one tick → fault[1].
- Lid: stage=RINSE with lid=1 for 2 ticks then 0 → no fault; lid=1 for 3 ticks → fault[2] set on the 3rd tick.
- Reset mid-RINSE with level=9, fault[0]=1 → all outputs 0 at once; next stage IDLE→WASH → fault[1] set.
